// File: rtl/camera_capture_win_if.sv
// camera_capture_win_if: frame-buffer write bus between the capture block and the memory arbiter
interface camera_capture_win_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic                mem_request;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [2*DATA_W-1:0] mem_din;
    logic                mem_ack;
    modport master (output mem_request, mem_we, mem_addr, mem_din, input mem_ack);
    modport slave (input mem_request, mem_we, mem_addr, mem_din, output mem_ack);
endinterface

// File: rtl/camera_capture_win.sv
// camera_capture_win: camera byte stream to frame-buffer writer; define CAMERA_CAPTURE_DECIM_EN for 2:1 decimation
module camera_capture_win #(
    parameter int DATA_W     = 8,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 camera_clk,
    input  logic                 camera_rst_n,
    input  logic                 start,
    input  logic                 decim,
    input  logic                 camera_vsync,
    input  logic                 camera_href,
    input  logic [DATA_W-1:0]    camera_dout,
    camera_capture_win_if.master mem,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 frame_err
);
    localparam int PW    = 2 * DATA_W;
    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int LIN_W = $clog2(2 * V_ACTIVE + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [COL_W-1:0]  H_MAX  = COL_W'(H_ACTIVE);
    localparam logic [LIN_W-1:0]  V_FULL = LIN_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  FULL   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DRAIN, DONE} state_t;

    state_t              state, state_n;
    logic                vsync_q, vsync_d, href_q, href_d;
    logic [DATA_W-1:0]   dout_q, upper;
    logic                phase, row_has_byte;
    logic [COL_W-1:0]    col;
    logic [LIN_W-1:0]    row, target;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [PW-1:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                cap, vs_rise, vs_fall, href_fall, pix_done, keep, take;
    logic                push, pop, row_end, last_row, arm_ok;

`ifdef CAMERA_CAPTURE_DECIM_EN
    localparam logic [LIN_W-1:0] V_DEC = LIN_W'(2 * V_ACTIVE);
    logic decim_q;
    assign keep   = col < H_MAX && (!decim_q || (!col[0] && !row[0]));
    assign target = decim_q ? V_DEC : V_FULL;
`else
    logic decim_unused;
    assign decim_unused = decim;
    assign keep   = col < H_MAX;
    assign target = V_FULL;
`endif

    assign cap       = state == CAPTURE;
    assign vs_rise   = vsync_q & ~vsync_d;
    assign vs_fall   = ~vsync_q & vsync_d;
    assign href_fall = href_d & ~href_q;
    assign arm_ok    = start && (state == IDLE || state == DONE);
    assign pix_done  = cap & href_q & phase;
    assign take      = pix_done & keep;
    assign pop       = mem.mem_request & mem.mem_ack;
    assign push      = take & ((count != FULL) | pop);
    assign row_end   = cap & href_fall & row_has_byte;
    assign last_row  = row_end && (row + LIN_W'(1) == target);

    assign mem.mem_request = count != '0;
    assign mem.mem_we      = mem.mem_request;
    assign mem.mem_addr    = mem.mem_request ? fifo_addr[rd_ptr] : '0;
    assign mem.mem_din     = mem.mem_request ? fifo_data[rd_ptr] : '0;

    // state register
    always_ff @(posedge camera_clk or negedge camera_rst_n)
        if (!camera_rst_n) state <= IDLE;
        else state <= state_n;

    // next state and status; DONE is entered as soon as the last entry is being acknowledged
    always_comb begin
        state_n = state;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = ARM;
            end
            ARM:     if (vs_rise) state_n = SYNC;
            SYNC:    if (vs_fall) state_n = CAPTURE;
            CAPTURE: if (vs_rise || last_row) state_n = DRAIN;
            DRAIN:   if (count == '0 || (count == CNT_W'(1) && pop)) state_n = DONE;
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_n = ARM;
            end
            default: state_n = IDLE;
        endcase
    end

    // input sampling, byte packing, column/row/address counters and sticky flags
    always_ff @(posedge camera_clk or negedge camera_rst_n)
        if (!camera_rst_n) begin
            {vsync_q, vsync_d, href_q, href_d} <= '0;
            dout_q       <= '0;
            upper        <= '0;
            phase        <= 1'b0;
            row_has_byte <= 1'b0;
            col          <= '0;
            row          <= '0;
            addr         <= '0;
            overflow     <= 1'b0;
            frame_err    <= 1'b0;
`ifdef CAMERA_CAPTURE_DECIM_EN
            decim_q      <= 1'b0;
`endif
        end else begin
            {vsync_d, vsync_q} <= {vsync_q, camera_vsync};
            {href_d, href_q}   <= {href_q, camera_href};
            dout_q             <= camera_dout;
            if (arm_ok) begin
                overflow  <= 1'b0;
                frame_err <= 1'b0;
`ifdef CAMERA_CAPTURE_DECIM_EN
                decim_q   <= decim;
`endif
            end
            if (state == SYNC && vs_fall) begin
                addr         <= BASE;
                col          <= '0;
                row          <= '0;
                phase        <= 1'b0;
                row_has_byte <= 1'b0;
            end
            if (cap && href_q) begin
                phase        <= ~phase;
                row_has_byte <= 1'b1;
                if (!phase) upper <= dout_q;
            end
            if (pix_done && col != H_MAX) col <= col + COL_W'(1);
            if (take) addr <= addr + ADDR_W'(1);
            if (take && !push) overflow <= 1'b1;
            if (cap && vs_rise) frame_err <= 1'b1;
            if (cap && href_fall) begin
                phase <= 1'b0;
                col   <= '0;
                if (row_has_byte) begin
                    row          <= row + LIN_W'(1);
                    row_has_byte <= 1'b0;
                end
            end
        end

    // pixel FIFO pointers; a pop in the same cycle makes room for a push into a full FIFO
    always_ff @(posedge camera_clk or negedge camera_rst_n)
        if (!camera_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end

    // pixel FIFO storage
    always_ff @(posedge camera_clk)
        if (push) begin
            fifo_addr[wr_ptr] <= addr;
            fifo_data[wr_ptr] <= {upper, dout_q};
        end
endmodule

// File: tb/tb_camera_capture_win.sv
// tb_camera_capture_win: directed frames with a write scoreboard for camera_capture_win
module tb_camera_capture_win;
    localparam int DW = 8, H = 10, V = 4, AW = 19, BASE = 32'h100, DEPTH = 4;
    localparam int EW = AW + 2 * DW;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, decim = 1'b0;
    logic          vsync = 1'b0, href = 1'b0;
    logic [DW-1:0] dout = '0;
    logic          busy, done, overflow, frame_err;
    int            checks = 0, errors = 0;
    logic [EW-1:0] exp_q[$], obs_q[$];
    int            stall_bad = 0, we_bad = 0;
    logic          stall_prev = 1'b0;
    logic [EW-1:0] held = '0;
    int            model_addr = BASE, model_target = V;
    logic          model_decim = 1'b0;

    always #5 clk = ~clk;

    camera_capture_win_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    camera_capture_win #(
        .DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .camera_clk(clk), .camera_rst_n(rst_n), .start(start), .decim(decim),
        .camera_vsync(vsync), .camera_href(href), .camera_dout(dout), .mem(mem),
        .busy(busy), .done(done), .overflow(overflow), .frame_err(frame_err)
    );

    // write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem.mem_we !== mem.mem_request) we_bad++;
        if (stall_prev && mem.mem_request && {mem.mem_addr, mem.mem_din} !== held) stall_bad++;
        if (mem.mem_request && mem.mem_ack) obs_q.push_back({mem.mem_addr, mem.mem_din});
        stall_prev = mem.mem_request && !mem.mem_ack;
        held = {mem.mem_addr, mem.mem_din};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic d);
        decim = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        decim = 1'b0;
        model_addr = BASE;
`ifdef CAMERA_CAPTURE_DECIM_EN
        model_decim = d;
`else
        model_decim = 1'b0;
`endif
        model_target = model_decim ? 2 * V : V;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (2) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drive_bytes(input int n, input int ack_rise);
        for (int i = 0; i < n; i++) begin
            if (i == ack_rise) mem.mem_ack = 1'b1;
            href = 1'b1;
            dout = DW'(i);
            tick();
        end
    endtask

    task automatic drive_line(input int n, input int ln, input int ack_rise, input int drop_from, input int drop_to);
        if (ln < model_target)
            for (int k = 0; k < n / 2 && k < H; k++)
                if (!model_decim || (k % 2 == 0 && ln % 2 == 0)) begin
                    if (k < drop_from || k > drop_to)
                        exp_q.push_back({AW'(model_addr), DW'(2 * k), DW'(2 * k + 1)});
                    model_addr++;
                end
        drive_bytes(n, ack_rise);
        href = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " busy"}, busy, 0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, " write count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk({tag, " write"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        mem.mem_ack = 1'b1;
        repeat (3) tick();
        chk("reset request", mem.mem_request, 0);
        chk("reset we", mem.mem_we, 0);
        chk("reset addr", mem.mem_addr, 0);
        chk("reset din", mem.mem_din, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset overflow", overflow, 0);
        chk("reset frame_err", frame_err, 0);
        rst_n = 1'b1;
        tick();

        // full frame
        do_start(1'b0);
        chk("armed busy", busy, 1);
        vsync_pulse();
        for (int l = 0; l < 4; l++) drive_line(20, l, -1, -1, -1);
        wait_done("full");
        repeat (3) tick();
        chk("full done held", done, 1);
        chk("full overflow", overflow, 0);
        chk("full frame_err", frame_err, 0);
        check_writes("full");

        // decimation, 8 camera lines
        do_start(1'b1);
        vsync_pulse();
        for (int l = 0; l < 8; l++) drive_line(20, l, -1, -1, -1);
        wait_done("decim");
        chk("decim overflow", overflow, 0);
        check_writes("decim");

        // backpressure on the first line: pixels 5 and 6 dropped
        do_start(1'b0);
        vsync_pulse();
        mem.mem_ack = 1'b0;
        drive_line(20, 0, 13, 4, 5);
        for (int l = 1; l < 4; l++) drive_line(20, l, -1, -1, -1);
        wait_done("stall");
        chk("stall overflow", overflow, 1);
        chk("stall frame_err", frame_err, 0);
        chk("stall stable", stall_bad, 0);
        check_writes("stall");

        // short frame
        do_start(1'b0);
        chk("start clears overflow", overflow, 0);
        vsync_pulse();
        for (int l = 0; l < 2; l++) drive_line(20, l, -1, -1, -1);
        vsync_pulse();
        wait_done("short");
        chk("short frame_err", frame_err, 1);
        check_writes("short");

        // odd and over-long lines
        do_start(1'b0);
        chk("start clears frame_err", frame_err, 0);
        vsync_pulse();
        drive_line(21, 0, -1, -1, -1);
        drive_line(25, 1, -1, -1, -1);
        drive_line(20, 2, -1, -1, -1);
        drive_line(23, 3, -1, -1, -1);
        wait_done("odd");
        chk("odd frame_err", frame_err, 0);
        check_writes("odd");

        // reset in the middle of line 2
        do_start(1'b0);
        vsync_pulse();
        drive_line(20, 0, -1, -1, -1);
        for (int k = 0; k < 4; k++) exp_q.push_back({AW'(model_addr + k), DW'(2 * k), DW'(2 * k + 1)});
        drive_bytes(10, -1);
        rst_n = 1'b0;
        #1;
        chk("midreset request", mem.mem_request, 0);
        chk("midreset addr", mem.mem_addr, 0);
        chk("midreset din", mem.mem_din, 0);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        tick();
        rst_n = 1'b1;
        drive_bytes(10, -1);
        href = 1'b0;
        repeat (3) tick();
        vsync_pulse();
        drive_bytes(20, -1);
        href = 1'b0;
        repeat (10) tick();
        chk("after reset idle", busy, 0);
        check_writes("midreset");

        // recovery frame after reset
        do_start(1'b0);
        vsync_pulse();
        for (int l = 0; l < 4; l++) drive_line(20, l, -1, -1, -1);
        wait_done("recover");
        check_writes("recover");
        chk("mem_we tracks request", we_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
